// File: rtl/pe_result_collector.sv
// Collects results from NUM_PE processing elements into one pending slot per PE and
// serializes them onto a valid/ready stream with round-robin arbitration.
// Optional feature macro: PE_COLLECT_ACTSUM_EN adds an activation-sum word that travels
// with each data word (pe_actsum in, out_actsum out, per-slot actsum storage).
module pe_result_collector #(
  parameter int NUM_PE = 8,
  parameter int DATA_W = 32,
  parameter int IDX_W  = (($clog2(NUM_PE) > 1) ? $clog2(NUM_PE) : 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_PE-1:0]        pe_valid,
  input  logic [NUM_PE*DATA_W-1:0] pe_data,
`ifdef PE_COLLECT_ACTSUM_EN
  input  logic [NUM_PE*DATA_W-1:0] pe_actsum,
`endif
  input  logic                     clr_ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
`ifdef PE_COLLECT_ACTSUM_EN
  output logic [DATA_W-1:0]        out_actsum,
`endif
  output logic [IDX_W-1:0]         out_pe_idx,
  output logic [NUM_PE-1:0]        ovf_flag
);

  // Pending slots
  logic [NUM_PE-1:0] pend_q, pend_d;
  logic [DATA_W-1:0] data_q [NUM_PE];
  logic [DATA_W-1:0] data_d [NUM_PE];
`ifdef PE_COLLECT_ACTSUM_EN
  logic [DATA_W-1:0] act_q [NUM_PE];
  logic [DATA_W-1:0] act_d [NUM_PE];
  logic [DATA_W-1:0] out_act_q, out_act_d;
`else
  // Without actsum only the data word is stored and forwarded.
`endif

  // Output register and arbiter state
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [NUM_PE-1:0] ovf_q, ovf_d;
  logic [NUM_PE-1:0] ovf_set;

  logic              grant_found;
  logic [IDX_W-1:0]  grant_idx;
  logic [NUM_PE-1:0] grant_oh;
  logic              load;
  // One extra bit so last_grant + k (up to 2*NUM_PE-1) never wraps before the modulo step
  logic [IDX_W:0]    cand;

  // Round-robin search: first pending PE starting after the last grant
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_PE; k++) begin
      cand = {1'b0, last_grant_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_PE)) begin
        cand = cand - (IDX_W+1)'(NUM_PE);
      end
      if (!grant_found && pend_q[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Output register is free to reload when empty or being consumed this cycle
  always_comb begin
    load     = (!out_valid_q || out_ready) && grant_found;
    grant_oh = '0;
    if (load) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  // Next state: load granted slot, capture new results, flag dropped ones
  always_comb begin
    pend_d       = pend_q;
    data_d       = data_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_idx_d    = out_idx_q;
    ovf_set      = '0;
`ifdef PE_COLLECT_ACTSUM_EN
    act_d        = act_q;
    out_act_d    = out_act_q;
`endif

    if (load) begin
      out_valid_d          = 1'b1;
      out_data_d           = data_q[grant_idx];
      out_idx_d            = grant_idx;
      last_grant_d         = grant_idx;
      pend_d[grant_idx]    = 1'b0;
`ifdef PE_COLLECT_ACTSUM_EN
      out_act_d            = act_q[grant_idx];
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // A slot being granted this cycle can accept a new result in the same cycle
    for (int i = 0; i < NUM_PE; i++) begin
      if (pe_valid[i]) begin
        if (!pend_q[i] || grant_oh[i]) begin
          data_d[i] = pe_data[i*DATA_W +: DATA_W];
          pend_d[i] = 1'b1;
`ifdef PE_COLLECT_ACTSUM_EN
          act_d[i]  = pe_actsum[i*DATA_W +: DATA_W];
`endif
        end else begin
          ovf_set[i] = 1'b1;
        end
      end
    end

    // Set takes priority over clear
    ovf_d = (ovf_q & ~{NUM_PE{clr_ovf}}) | ovf_set;
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q       <= '0;
      last_grant_q <= IDX_W'(NUM_PE - 1);
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      ovf_q        <= '0;
      for (int i = 0; i < NUM_PE; i++) begin
        data_q[i] <= '0;
`ifdef PE_COLLECT_ACTSUM_EN
        act_q[i]  <= '0;
`endif
      end
`ifdef PE_COLLECT_ACTSUM_EN
      out_act_q    <= '0;
`endif
    end else begin
      pend_q       <= pend_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_idx_q    <= out_idx_d;
      ovf_q        <= ovf_d;
      data_q       <= data_d;
`ifdef PE_COLLECT_ACTSUM_EN
      act_q        <= act_d;
      out_act_q    <= out_act_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_pe_idx = out_idx_q;
  assign ovf_flag   = ovf_q;
`ifdef PE_COLLECT_ACTSUM_EN
  assign out_actsum = out_act_q;
`endif

endmodule
